// File: rtl/exe_stage_pkg.sv
// Shared encodings for the Sloth execute stage: commands, shift types,
// NZCV bit positions and multiplier FSM states.
package exe_stage_pkg;

   localparam int WORD_W = 32;
   localparam int SIMM_W = 24;
   localparam int SO_W   = 12;
   localparam int RF_W   = 4;

   typedef enum logic [3:0] {
      CMD_NOP = 4'b0000,
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001,
      CMD_MUL = 4'b1010
   } ex_cmd_t;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mul_state_t;

   localparam logic [4:0] MUL_LAST = 5'd31;

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Second-operand generator: memory offset, rotated immediate,
// or shifted Rm. Purely combinational.
module val2_generator
   import exe_stage_pkg::*;
#(
   parameter int WORD_WIDTH            = WORD_W,
   parameter int SHIFTER_OPERAND_WIDTH = SO_W
) (
   input  logic [WORD_WIDTH-1:0]            i_val_rm,
   input  logic [SHIFTER_OPERAND_WIDTH-1:0] i_shifter_operand,
   input  logic                             i_imm,
   input  logic                             i_mem_op,
   output logic [WORD_WIDTH-1:0]            o_val2
);

   logic [WORD_WIDTH-1:0] w_imm8;
   logic [5:0]            w_rot;
   logic [5:0]            w_shamt;
   logic [WORD_WIDTH-1:0] w_imm_rot;
   logic [WORD_WIDTH-1:0] w_rm_ror;

   assign w_imm8  = {{(WORD_WIDTH-8){1'b0}}, i_shifter_operand[7:0]};
   assign w_rot   = {1'b0, i_shifter_operand[11:8], 1'b0};
   assign w_shamt = {1'b0, i_shifter_operand[11:7]};

   // A zero rotate makes the left shift 32, which yields 0 and keeps the value
   assign w_imm_rot = (w_imm8 >> w_rot) | (w_imm8 << (6'd32 - w_rot));
   assign w_rm_ror  = (i_val_rm >> w_shamt) | (i_val_rm << (6'd32 - w_shamt));

   // Select the operand source; a zero shift amount leaves Rm untouched
   always_comb begin
      o_val2 = i_val_rm;
      if (i_mem_op) begin
         o_val2 = {{(WORD_WIDTH-SHIFTER_OPERAND_WIDTH){1'b0}}, i_shifter_operand};
      end else if (i_imm) begin
         o_val2 = w_imm_rot;
      end else begin
         case (shift_t'(i_shifter_operand[6:5]))
            SH_LSL: o_val2 = i_val_rm << w_shamt;
            SH_LSR: o_val2 = i_val_rm >> w_shamt;
            SH_ASR: o_val2 = $signed(i_val_rm) >>> w_shamt;
            SH_ROR: o_val2 = w_rm_ror;
         endcase
      end
   end

endmodule

// File: rtl/exe_stage.sv
// Sloth execute stage: ALU, NZCV register, EX/MEM register, branch target.
// Define EXE_MUL_EN to build the 32-cycle shift-add multiplier.
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int WORD_WIDTH            = WORD_W,
   parameter int SIGNED_IMM_WIDTH      = SIMM_W,
   parameter int SHIFTER_OPERAND_WIDTH = SO_W,
   parameter int REG_FILE_DEPTH        = RF_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [WORD_WIDTH-1:0]            pc_in,
   input  logic [WORD_WIDTH-1:0]            val1_in,
   input  logic [WORD_WIDTH-1:0]            val_rm_in,
   input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate_in,
   input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
   input  logic [3:0]                       EX_command_in,
   input  logic                             Imm_in,
   input  logic                             B_in,
   input  logic                             update_in,
   input  logic                             mem_read_in,
   input  logic                             mem_write_in,
   input  logic                             WB_en_in,
   input  logic [REG_FILE_DEPTH-1:0]        reg_file_dst_in,
   output logic [WORD_WIDTH-1:0]            alu_result_out,
   output logic [WORD_WIDTH-1:0]            store_data_out,
   output logic [REG_FILE_DEPTH-1:0]        reg_file_dst_out,
   output logic                             mem_read_out,
   output logic                             mem_write_out,
   output logic                             WB_en_out,
   output logic [3:0]                       status_register_out,
   output logic                             branch_taken,
   output logic [WORD_WIDTH-1:0]            branch_address,
   output logic                             exe_stall
);

   logic [WORD_WIDTH-1:0] w_val2;
   logic [WORD_WIDTH-1:0] w_b;
   logic [WORD_WIDTH-1:0] w_res;
   logic [WORD_WIDTH:0]   w_sum;
   logic                  w_cin;
   logic                  w_arith;
   logic                  w_logic;
   logic [3:0]            w_status_next;
   logic                  w_mul_op;
   logic [WORD_WIDTH-1:0] w_mul_res;
   logic                  w_stall;

   val2_generator #(
      .WORD_WIDTH            (WORD_WIDTH),
      .SHIFTER_OPERAND_WIDTH (SHIFTER_OPERAND_WIDTH)
   ) u_val2 (
      .i_val_rm          (val_rm_in),
      .i_shifter_operand (shifter_operand_in),
      .i_imm             (Imm_in),
      .i_mem_op          (mem_read_in | mem_write_in),
      .o_val2            (w_val2)
   );

   assign branch_taken   = B_in;
   assign branch_address = pc_in + {{(WORD_WIDTH-SIGNED_IMM_WIDTH-2){signed_immediate_in[SIGNED_IMM_WIDTH-1]}},
                                    signed_immediate_in, 2'b00};
   assign exe_stall      = w_stall;

`ifdef EXE_MUL_EN
   mul_state_t            r_state;
   mul_state_t            w_state_next;
   logic [WORD_WIDTH-1:0] r_mcand;
   logic [WORD_WIDTH-1:0] r_mplier;
   logic [WORD_WIDTH-1:0] r_acc;
   logic [WORD_WIDTH-1:0] w_acc_next;
   logic [4:0]            r_cnt;

   assign w_mul_op   = (EX_command_in == CMD_MUL);
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_res  = w_acc_next;

   // Multiplier state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next state; upstream is held until the last partial product is added
   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_mul_op) begin
               w_state_next = ST_BUSY;
               w_stall      = 1'b1;
            end
         end
         ST_BUSY: begin
            if (r_cnt == MUL_LAST) w_state_next = ST_IDLE;
            else                   w_stall      = 1'b1;
         end
      endcase
   end

   // Shift-add datapath, one multiplier bit per busy cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (r_state == ST_IDLE && w_mul_op) begin
         r_mcand  <= val1_in;
         r_mplier <= w_val2;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (r_state == ST_BUSY) begin
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_acc    <= w_acc_next;
         r_cnt    <= r_cnt + 5'd1;
      end
   end
`else
   assign w_mul_op  = 1'b0;
   assign w_mul_res = '0;
   assign w_stall   = 1'b0;
`endif

   // ALU: subtraction is addition of the inverted operand plus carry-in
   always_comb begin
      w_b     = w_val2;
      w_cin   = 1'b0;
      w_arith = 1'b0;
      w_logic = 1'b0;
      w_res   = '0;
      case (ex_cmd_t'(EX_command_in))
         CMD_MOV: begin w_res = w_val2;  w_logic = 1'b1; end
         CMD_MVN: begin w_res = ~w_val2; w_logic = 1'b1; end
         CMD_ADD: w_arith = 1'b1;
         CMD_ADC: begin
            w_arith = 1'b1;
            w_cin   = status_register_out[FLAG_C];
         end
         CMD_SUB: begin
            w_arith = 1'b1;
            w_b     = ~w_val2;
            w_cin   = 1'b1;
         end
         CMD_SBC: begin
            w_arith = 1'b1;
            w_b     = ~w_val2;
            w_cin   = status_register_out[FLAG_C];
         end
         CMD_AND: begin w_res = val1_in & w_val2; w_logic = 1'b1; end
         CMD_ORR: begin w_res = val1_in | w_val2; w_logic = 1'b1; end
         CMD_EOR: begin w_res = val1_in ^ w_val2; w_logic = 1'b1; end
         CMD_MUL: begin
            if (w_mul_op) begin
               w_res   = w_mul_res;
               w_logic = 1'b1;
            end
         end
         default: ;
      endcase
      w_sum = {1'b0, val1_in} + {1'b0, w_b} + {{WORD_WIDTH{1'b0}}, w_cin};
      if (w_arith) w_res = w_sum[WORD_WIDTH-1:0];
   end

   // Flag update: logic ops and MUL keep C and V
   always_comb begin
      w_status_next = status_register_out;
      if (w_arith || w_logic) begin
         w_status_next[FLAG_N] = w_res[WORD_WIDTH-1];
         w_status_next[FLAG_Z] = (w_res == '0);
      end
      if (w_arith) begin
         w_status_next[FLAG_C] = w_sum[WORD_WIDTH];
         w_status_next[FLAG_V] = (val1_in[WORD_WIDTH-1] == w_b[WORD_WIDTH-1]) &&
                                 (w_res[WORD_WIDTH-1] != val1_in[WORD_WIDTH-1]);
      end
   end

   // EX/MEM register and NZCV; a stall loads a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_result_out      <= '0;
         store_data_out      <= '0;
         reg_file_dst_out    <= '0;
         mem_read_out        <= 1'b0;
         mem_write_out       <= 1'b0;
         WB_en_out           <= 1'b0;
         status_register_out <= '0;
      end else begin
         alu_result_out   <= w_stall ? '0 : w_res;
         store_data_out   <= val_rm_in;
         reg_file_dst_out <= reg_file_dst_in;
         mem_read_out     <= mem_read_in & ~w_stall;
         mem_write_out    <= mem_write_in & ~w_stall;
         WB_en_out        <= WB_en_in & ~w_stall;
         if (update_in && !w_stall) status_register_out <= w_status_next;
      end
   end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage with a behavioural model.
// Follows EXE_MUL_EN the same way the design does.
module tb_exe_stage;

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic [31:0] v1;
      logic [31:0] rm;
      logic [23:0] imm;
      logic [11:0] so;
      logic [3:0]  cmd;
      logic        im, b, upd, mr, mw, wb;
      logic [3:0]  dst;
   } ins_t;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in, val1_in, val_rm_in;
   logic [23:0] signed_immediate_in;
   logic [11:0] shifter_operand_in;
   logic [3:0]  EX_command_in;
   logic        Imm_in, B_in, update_in, mem_read_in, mem_write_in, WB_en_in;
   logic [3:0]  reg_file_dst_in;
   logic [31:0] alu_result_out, store_data_out;
   logic [3:0]  reg_file_dst_out;
   logic        mem_read_out, mem_write_out, WB_en_out;
   logic [3:0]  status_register_out;
   logic        branch_taken;
   logic [31:0] branch_address;
   logic        exe_stall;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   ins_t        cur;
   int          m_cnt;
   logic [31:0] e_res, e_store, e_ba;
   logic        e_res_vld, e_mr, e_mw, e_wb, e_stall, e_bt;
   logic [3:0]  e_dst, e_stat;

   exe_stage dut (
      .clk                 (clk),
      .rst                 (rst),
      .pc_in               (pc_in),
      .val1_in             (val1_in),
      .val_rm_in           (val_rm_in),
      .signed_immediate_in (signed_immediate_in),
      .shifter_operand_in  (shifter_operand_in),
      .EX_command_in       (EX_command_in),
      .Imm_in              (Imm_in),
      .B_in                (B_in),
      .update_in           (update_in),
      .mem_read_in         (mem_read_in),
      .mem_write_in        (mem_write_in),
      .WB_en_in            (WB_en_in),
      .reg_file_dst_in     (reg_file_dst_in),
      .alu_result_out      (alu_result_out),
      .store_data_out      (store_data_out),
      .reg_file_dst_out    (reg_file_dst_out),
      .mem_read_out        (mem_read_out),
      .mem_write_out       (mem_write_out),
      .WB_en_out           (WB_en_out),
      .status_register_out (status_register_out),
      .branch_taken        (branch_taken),
      .branch_address      (branch_address),
      .exe_stall           (exe_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic is_mul(input ins_t x);
`ifdef EXE_MUL_EN
      return x.cmd == 4'd10;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_val2(input ins_t x);
      longint t;
      int     n;
      if (x.mr || x.mw) return {20'd0, x.so};
      if (x.im) begin
         n = int'(x.so[11:8]) * 2;
         t = longint'(x.so[7:0]);
         t = (t >> n) | (t << (32 - n));
         return 32'(t);
      end
      n = int'(x.so[11:7]);
      if (n == 0) return x.rm;
      case (x.so[6:5])
         2'd0: return x.rm << n;
         2'd1: return x.rm >> n;
         2'd2: return 32'($signed(x.rm) >>> n);
         default: begin
            t = longint'(x.rm);
            t = (t >> n) | (t << (32 - n));
            return 32'(t);
         end
      endcase
   endfunction

   task automatic model_alu(input ins_t x, input logic [3:0] st,
                            output logic [31:0] r, output logic [3:0] nst);
      logic [31:0] v2;
      longint ua, ub, us, sa, sb, ss, c;
      int kind;
      logic cf;
      v2 = model_val2(x);
      c  = st[1] ? 64'sd1 : 64'sd0;
      ua = longint'(x.v1);
      ub = longint'(v2);
      sa = longint'($signed(x.v1));
      sb = longint'($signed(v2));
      us = 0; ss = 0; cf = 1'b0; kind = 0; r = '0;
      case (x.cmd)
         4'd1: begin r = v2;        kind = 1; end
         4'd9: begin r = ~v2;       kind = 1; end
         4'd6: begin r = x.v1 & v2; kind = 1; end
         4'd7: begin r = x.v1 | v2; kind = 1; end
         4'd8: begin r = x.v1 ^ v2; kind = 1; end
         4'd2: begin us = ua + ub;     ss = sa + sb;     cf = us >= 64'sd4294967296; kind = 2; end
         4'd3: begin us = ua + ub + c; ss = sa + sb + c; cf = us >= 64'sd4294967296; kind = 2; end
         4'd4: begin us = ua - ub;     ss = sa - sb;     cf = us >= 0; kind = 2; end
         4'd5: begin
            us = ua - ub - (1 - c);
            ss = sa - sb - (1 - c);
            cf = us >= 0;
            kind = 2;
         end
`ifdef EXE_MUL_EN
         4'd10: begin r = 32'(ua * ub); kind = 1; end
`endif
         default: ;
      endcase
      if (kind == 2) r = 32'(us);
      nst = st;
      if (kind != 0) begin
         nst[3] = r[31];
         nst[2] = (r == 32'd0);
      end
      if (kind == 2) begin
         nst[1] = cf;
         nst[0] = (ss > SMAX) || (ss < SMIN);
      end
   endtask

   task automatic calc_comb();
      int off;
      e_stall = is_mul(cur) && (m_cnt < 32);
      e_bt    = cur.b;
      off     = int'(cur.imm);
      if (cur.imm[23]) off = off - 16777216;
      e_ba    = cur.pc + 32'(off * 4);
   endtask

   // Advance the model across the clock edge using the inputs held before it
   task automatic model_update();
      logic [31:0] r;
      logic [3:0]  ns;
      if (cur.rst) begin
         e_res = '0; e_res_vld = 1'b1; e_store = '0; e_dst = '0;
         e_mr = 1'b0; e_mw = 1'b0; e_wb = 1'b0; e_stat = '0;
         m_cnt = 0;
      end else begin
         e_store = cur.rm;
         e_dst   = cur.dst;
         e_mr    = cur.mr & ~e_stall;
         e_mw    = cur.mw & ~e_stall;
         e_wb    = cur.wb & ~e_stall;
         if (e_stall) begin
            m_cnt++;
            e_res_vld = 1'b0;
         end else begin
            model_alu(cur, e_stat, r, ns);
            e_res = r;
            e_res_vld = 1'b1;
            if (cur.upd) e_stat = ns;
            if (is_mul(cur)) m_cnt = 0;
         end
      end
      calc_comb();
   endtask

   task automatic apply(input ins_t x);
      cur                 = x;
      rst                 = x.rst;
      pc_in               = x.pc;
      val1_in             = x.v1;
      val_rm_in           = x.rm;
      signed_immediate_in = x.imm;
      shifter_operand_in  = x.so;
      EX_command_in       = x.cmd;
      Imm_in              = x.im;
      B_in                = x.b;
      update_in           = x.upd;
      mem_read_in         = x.mr;
      mem_write_in        = x.mw;
      WB_en_in            = x.wb;
      reg_file_dst_in     = x.dst;
      calc_comb();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_update();
   endtask

   function automatic ins_t mk(input logic [3:0] cmd, input logic [31:0] v1,
                               input logic [31:0] rm, input logic [11:0] so,
                               input logic im, input logic upd);
      ins_t x;
      x.rst = 1'b0; x.pc = 32'h0; x.v1 = v1; x.rm = rm; x.imm = 24'h0;
      x.so = so; x.cmd = cmd; x.im = im; x.b = 1'b0; x.upd = upd;
      x.mr = 1'b0; x.mw = 1'b0; x.wb = 1'b1; x.dst = 4'd5;
      return x;
   endfunction

   function automatic logic [31:0] sp();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic ins_t rnd();
      ins_t x;
      x.rst = ($urandom_range(0, 63) == 0);
      x.pc  = $urandom;
      x.v1  = sp();
      x.rm  = sp();
      x.imm = 24'($urandom);
      x.so  = 12'($urandom);
      x.cmd = 4'($urandom_range(0, 15));
      if (x.cmd == 4'd10 && $urandom_range(0, 3) != 0) x.cmd = 4'd3;
      if (x.rst) x.cmd = 4'd0;
      x.im  = 1'($urandom);
      x.b   = 1'($urandom);
      x.upd = 1'($urandom);
      x.mr  = ($urandom_range(0, 7) == 0);
      x.mw  = ($urandom_range(0, 7) == 0);
      x.wb  = 1'($urandom);
      x.dst = 4'($urandom);
      return x;
   endfunction

   // Compare every output against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("exe_stall", {31'd0, exe_stall}, {31'd0, e_stall});
         chk("branch_taken", {31'd0, branch_taken}, {31'd0, e_bt});
         chk("branch_address", branch_address, e_ba);
         chk("WB_en_out", {31'd0, WB_en_out}, {31'd0, e_wb});
         chk("mem_read_out", {31'd0, mem_read_out}, {31'd0, e_mr});
         chk("mem_write_out", {31'd0, mem_write_out}, {31'd0, e_mw});
         chk("reg_file_dst_out", {28'd0, reg_file_dst_out}, {28'd0, e_dst});
         chk("store_data_out", store_data_out, e_store);
         chk("status_register_out", {28'd0, status_register_out}, {28'd0, e_stat});
         if (e_res_vld) chk("alu_result_out", alu_result_out, e_res);
      end
   end

   initial begin
      ins_t x;
      int   n;
      bit   s;
      m_cnt = 0;
      e_stat = '0;
      x = mk(4'd0, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0);
      x.rst = 1'b1;
      x.wb  = 1'b0;
      apply(x);
      step();
      chk_en = 1'b1;
      step();
      chk("reset_status", {28'd0, status_register_out}, 32'h0);
      chk("reset_result", alu_result_out, 32'h0);
      chk("reset_wb", {31'd0, WB_en_out}, 32'h0);

      apply(mk(4'd2, 32'h7FFF_FFFF, 32'h0, 12'h001, 1'b1, 1'b1));
      step();
      chk("add_result", alu_result_out, 32'h8000_0000);
      chk("add_nzcv", {28'd0, status_register_out}, 32'h9);

      apply(mk(4'd5, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1));
      step();
      chk("sbc_result", alu_result_out, 32'hFFFF_FFFF);
      chk("sbc_nzcv", {28'd0, status_register_out}, 32'h8);

      apply(mk(4'd1, 32'h0, 32'h0, 12'h2FF, 1'b1, 1'b0));
      step();
      chk("mov_rot_imm", alu_result_out, 32'hF000_000F);

      apply(mk(4'd1, 32'h0, 32'h8000_0000, 12'h0C0, 1'b0, 1'b0));
      step();
      chk("mov_asr1", alu_result_out, 32'hC000_0000);

      x = mk(4'd0, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0);
      x.b = 1'b1; x.pc = 32'h100; x.imm = 24'hFFFFFE;
      apply(x);
      #1;
      chk("branch_taken_lit", {31'd0, branch_taken}, 32'h1);
      chk("branch_addr_lit", branch_address, 32'h0000_00F8);
      step();

`ifdef EXE_MUL_EN
      apply(mk(4'd10, 32'd3, 32'hFFFF_FFFF, 12'h000, 1'b0, 1'b1));
      n = 0;
      #1;
      while (exe_stall && n < 40) begin
         n++;
         step();
         #1;
      end
      chk("mul_stall_cycles", n, 32'd32);
      step();
      chk("mul_result", alu_result_out, 32'hFFFF_FFFD);
      chk("mul_wb", {31'd0, WB_en_out}, 32'h1);
      chk("mul_nzcv", {28'd0, status_register_out}, 32'h8);

      x = mk(4'd10, 32'h1234, 32'h5678, 12'h000, 1'b0, 1'b0);
      apply(x);
      repeat (11) step();
      x.rst = 1'b1;
      apply(x);
      step();
      chk("rst_mid_mul_status", {28'd0, status_register_out}, 32'h0);
      chk("rst_mid_mul_wb", {31'd0, WB_en_out}, 32'h0);
      x.rst = 1'b0;
      apply(x);
      n = 0;
      #1;
      while (exe_stall && n < 40) begin
         n++;
         step();
         #1;
      end
      chk("mul_restart_stall", n, 32'd32);
      step();
      chk("mul_restart_result", alu_result_out, 32'h0626_0060);
`else
      apply(mk(4'd10, 32'd3, 32'hFFFF_FFFF, 12'h000, 1'b0, 1'b1));
      #1;
      chk("undef_mul_stall", {31'd0, exe_stall}, 32'h0);
      step();
      chk("undef_mul_result", alu_result_out, 32'h0);
      chk("undef_mul_nzcv", {28'd0, status_register_out}, 32'h8);
`endif

      apply(rnd());
      for (int i = 0; i < 3000; i++) begin
         s = e_stall;
         step();
         if (!s) apply(rnd());
      end
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the Sloth ARM-subset pipeline. It consumes the ID/EX pipeline register outputs, generates the second operand, runs the ALU and an optional iterative multiplier, and computes the branch target. It owns the NZCV status register and the EX/MEM pipeline register. While a multiply runs, it stalls everything upstream.

## Interface
- `WORD_WIDTH`, 32, datapath width (from `settings.h`)
- `SIGNED_IMM_WIDTH`, 24, branch offset width
- `SHIFTER_OPERAND_WIDTH`, 12, shifter operand width
- `REG_FILE_DEPTH`, 4, destination register index width
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `pc_in` in 32: PC+4 of the instruction
- `val1_in`, `val_rm_in` in 32: Rn and Rm register values
- `signed_immediate_in` in 24, `shifter_operand_in` in 12, `EX_command_in` in 4
- `Imm_in`, `B_in`, `update_in`, `mem_read_in`, `mem_write_in`, `WB_en_in` in 1 each
- `reg_file_dst_in` in 4
- `alu_result_out` out 32: EX/MEM result (registered)
- `store_data_out` out 32: registered Rm
- `reg_file_dst_out` out 4, `mem_read_out`, `mem_write_out`, `WB_en_out` out 1: registered
- `status_register_out` out 4: {N,Z,C,V}, registered
- `branch_taken` out 1, `branch_address` out 32: combinational
- `exe_stall` out 1: combinational; holds IF, IF/ID and ID/EX

## Operation
- **Val2 generation.**
  - Mem op: zero-extended `shifter_operand[11:0]`.
  - Imm=1: `{24'b0, so[7:0]}` rotated right by 2×`so[11:8]`.
  - Otherwise: Rm shifted by `so[11:7]`, with type `so[6:5]` = LSL/LSR/ASR/ROR. A shift of 0 passes Rm unchanged.
- **Commands.**
  - 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
  - 1010 MUL (low 32 bits of val1×val2).
  - Others produce result 0 and leave flags untouched.
  - ADC/SBC use C from `status_register_out`. SBC = val1 − val2 − ~C.
- **Flags.**
  - N = result[31], Z = (result==0).
  - C = carry-out for ADD/ADC; C = no-borrow for SUB/SBC.
  - V = signed overflow for add/sub.
  - Logic ops and MUL update only N and Z.
  - The status register is written only when `update_in` is high and the stage is not stalled.
- **Branch.**
  - `branch_taken` = `B_in`.
  - `branch_address` = `pc_in` + (sign-extended imm24 << 2), using 32-bit wraparound.
- **Multiplier FSM** (IDLE, BUSY):
  - IDLE→BUSY when a MUL is present. This loads mcand=val1, mplier=val2, acc=0, cnt=0.
  - In each BUSY cycle: if mplier[0], then acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
  - When cnt==31, the final acc_next is captured into EX/MEM and the FSM returns to IDLE.
- **Stall.** `exe_stall` = (IDLE && MUL present) || (BUSY && cnt≠31).
- **EX/MEM behaviour while stalled.** The EX/MEM register loads a bubble: WB_en, mem_read and mem_write are 0.

## Timing
- ALU ops: 1-cycle latency. Inputs in cycle T appear on the EX/MEM outputs at T+1.
- MUL presented in cycle T:
  - `exe_stall` is high in T through T+31.
  - It is low in T+32 (BUSY, cnt=31).
  - The result appears on the outputs at T+33.
- MUL immediately followed by MUL: the second MUL enters IDLE at T+33 and restarts.
- Reset values: all registered outputs are 0, including status 0000. The FSM goes to IDLE and cnt to 0.
- Reset during BUSY:
  - The FSM is aborted; no result is written.
  - If a MUL is still on the inputs after reset, stall re-asserts and the multiply restarts.
- Branch and stall in the same cycle: cannot happen, since a branch is never a MUL.

## Configuration
- **`EXE_MUL_EN` defined:** the FSM, accumulator and counter are built. Command 1010 is MUL.
- **`EXE_MUL_EN` undefined:** no FSM is built. `exe_stall` is tied to 0. Command 1010 behaves as an undefined command: result 0, flags untouched, 1-cycle latency.

## Structure
- Shared package / `settings.h` holds:
  - the EX_command encodings
  - the shift-type encodings
  - the flag bit indices (N=3, Z=2, C=1, V=0)
  - the FSM state constants
- One sub-module: `val2_generator`, purely combinational. It contains the rotate, shift and mem-offset logic.
- The ALU, multiplier FSM and EX/MEM register stay in `exe_stage`.

## Test plan
- **ADD with S-bit.** `ADD` val1=0x7FFFFFFF, Imm=1, so=0x001 (val2=1), update=1 → result 0x80000000 and NZCV=1001, both at the next edge.
- **SBC with carry clear.** `SBC` val1=5, Rm=5, so=0x000 → result 0xFFFFFFFF; with update=1, NZCV=1000.
- **Rotated immediate.** `MOV` Imm=1, so=0x2FF → result 0xF000000F. MOV with Rm=0x80000000, so=0x0C0 (ASR #1) → result 0xC0000000.
- **MUL.** `MUL` val1=3, val2=0xFFFFFFFF:
  - stall is high for exactly 32 cycles;
  - the result 0xFFFFFFFD appears 33 cycles after issue;
  - the EX/MEM register shows a bubble (WB_en=0) throughout the stall.
- **Reset mid-MUL.** `rst` at BUSY cnt=10 → outputs 0, FSM IDLE; the MUL restarts and completes correctly.
- **Branch.** `B_in`=1, pc_in=0x100, imm24=0xFFFFFE → `branch_taken`=1 and `branch_address`=0xF8 in the same cycle.
